// File: rtl/network_pkg.sv
// Shared crossbar definitions for the bank-input and bank-output networks.
// Provides the bank/lane count, select width and the inverse-route helper.
package network_pkg;

    localparam int N_BANK = 16;
    localparam int SEL_W  = 4;

    // Result of inverting a select set: which lanes are fed, and from which bank
    typedef struct packed {
        logic [N_BANK-1:0]       hit;
        logic [N_BANK*SEL_W-1:0] src;
    } inv_route_t;

    // For every lane, find the lowest-numbered bank that selected it.
    // Banks are scanned from the top down so the lowest index is written last.
    function automatic inv_route_t inv_route(input logic [N_BANK*SEL_W-1:0] sel);
        inv_route_t r;
        r = '0;
        for (int j = 0; j < N_BANK; j++) begin
            for (int i = N_BANK - 1; i >= 0; i--) begin
                if (sel[SEL_W*i +: SEL_W] == SEL_W'(j)) begin
                    r.hit[j]                = 1'b1;
                    r.src[SEL_W*j +: SEL_W] = SEL_W'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_delay_line.sv
// Valid + payload shift register with synchronous flush.
// Used to align issue-time selects with bank read data; also suits
// twiddle-address alignment. No stall: every stage shifts each cycle.
module sel_delay_line #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] pay [DEPTH];

    // Shift valid and payload; flush kills every valid including the one entering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) pay[k] <= '0;
        end else begin
            vld[0] <= in_valid & ~flush;
            pay[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1] & ~flush;
                pay[k] <= pay[k-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = pay[DEPTH-1];

endmodule

// File: rtl/network_bank_out.sv
// Return-path crossbar: routes bank read data back to the lanes that issued
// the addresses, using the issue-time selects delayed by the RAM latency.
// Optional feature macro: NETWORK_BANK_OUT_PERM_CHK_EN adds a registered
// perm_err flag raised when the aligned selects are not a full permutation.
module network_bank_out
    import network_pkg::*;
#(
    parameter int data_width = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [N_BANK*SEL_W-1:0]      sel_a_bus,
    input  logic [data_width*N_BANK-1:0] q_bus,
    output logic [data_width*N_BANK-1:0] rdata_bus,
    output logic                         rdata_valid,
    output logic [N_BANK-1:0]            lane_hit
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
    ,
    output logic                         perm_err
`endif
);

    logic                         al_valid;
    logic [N_BANK*SEL_W-1:0]      al_sel;
    inv_route_t                   rt;
    logic [data_width*N_BANK-1:0] routed;
    logic                         load;
    int                           src_idx;

    sel_delay_line #(
        .WIDTH (N_BANK*SEL_W),
        .DEPTH (RD_LAT)
    ) u_sel_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (issue_valid),
        .in_data   (sel_a_bus),
        .out_valid (al_valid),
        .out_data  (al_sel)
    );

    // Invert the aligned select set into per-lane source bank and hit mask
    always_comb rt = inv_route(al_sel);

    // Per-lane priority mux; unfed lanes return zero
    always_comb begin
        routed  = '0;
        src_idx = 0;
        for (int j = 0; j < N_BANK; j++) begin
            src_idx = int'(rt.src[SEL_W*j +: SEL_W]);
            if (rt.hit[j])
                routed[data_width*j +: data_width] = q_bus[data_width*src_idx +: data_width];
        end
    end

    // A flush in the aligned cycle also suppresses the output load
    assign load = al_valid & ~flush;

    // Output register: data and hit mask hold between returned sets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_bus   <= '0;
            rdata_valid <= 1'b0;
            lane_hit    <= '0;
        end else begin
            rdata_valid <= load;
            if (load) begin
                rdata_bus <= routed;
                lane_hit  <= rt.hit;
            end
        end
    end

`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
    // Flag a returned set whose selects left at least one lane unfed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perm_err <= 1'b0;
        else        perm_err <= load & ~(&rt.hit);
    end
`endif

endmodule

// File: tb/tb_network_bank_out.sv
// Bench for network_bank_out: three instances at RD_LAT 1, 2 and 3 share the
// issue/select/flush stimulus; each gets its own bank model delaying the data.
// Optional feature macro: NETWORK_BANK_OUT_PERM_CHK_EN.
module tb_network_bank_out;
    import network_pkg::*;

    localparam int DW = 12;
    localparam int NB = 16;
    localparam int BW = DW*NB;
    localparam int SW = 4*NB;
    localparam int NT = 45;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic [SW-1:0] sel_a_bus = '0;
    logic [BW-1:0] dset = '0;
    logic [BW-1:0] q1, q2a, q2, q3a, q3b, q3;
    logic [BW-1:0] rd  [3];
    logic          rv  [3];
    logic [NB-1:0] hit [3];
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
    logic          pe  [3];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Bank RAM models: read data appears RD_LAT cycles after the issue cycle
    always @(posedge clk) begin
        q1  <= dset;
        q2a <= dset;  q2  <= q2a;
        q3a <= dset;  q3b <= q3a;  q3 <= q3b;
    end

    network_bank_out #(.data_width(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
        .sel_a_bus(sel_a_bus), .q_bus(q1), .rdata_bus(rd[0]), .rdata_valid(rv[0]),
        .lane_hit(hit[0])
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
        , .perm_err(pe[0])
`endif
    );
    network_bank_out #(.data_width(DW), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
        .sel_a_bus(sel_a_bus), .q_bus(q2), .rdata_bus(rd[1]), .rdata_valid(rv[1]),
        .lane_hit(hit[1])
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
        , .perm_err(pe[1])
`endif
    );
    network_bank_out #(.data_width(DW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
        .sel_a_bus(sel_a_bus), .q_bus(q3), .rdata_bus(rd[2]), .rdata_valid(rv[2]),
        .lane_hit(hit[2])
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
        , .perm_err(pe[2])
`endif
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 identity, 1 reverse, 2 bit-reverse, 3 rotate by k, 4 duplicate (lane 7 unfed)
    function automatic logic [SW-1:0] make_sel(input int kind, input int k);
        logic [SW-1:0] s;
        logic [3:0]    b;
        s = '0;
        for (int i = 0; i < NB; i++) begin
            b = 4'(i);
            case (kind)
                1:       s[4*i +: 4] = 4'(15 - i);
                2:       s[4*i +: 4] = {b[0], b[1], b[2], b[3]};
                3:       s[4*i +: 4] = 4'((i + k) % 16);
                default: s[4*i +: 4] = b;
            endcase
        end
        if (kind == 4) begin
            s[4*3 +: 4] = 4'd5;
            s[4*5 +: 4] = 4'd3;
            s[4*7 +: 4] = 4'd9;
            s[4*9 +: 4] = 4'd5;
        end
        return s;
    endfunction

    // Bank word i for schedule slot m; top bit set to expose any truncation
    function automatic logic [BW-1:0] make_data(input int m);
        logic [BW-1:0] d;
        for (int i = 0; i < NB; i++) d[DW*i +: DW] = 12'h800 | 12'(m*16 + i);
        return d;
    endfunction

    // Reference: for each lane scan banks upward, first match feeds the lane
    function automatic void route_model(input logic [SW-1:0] sel, input logic [BW-1:0] d,
                                        output logic [BW-1:0] o, output logic [NB-1:0] h);
        bit found;
        o = '0;
        h = '0;
        for (int j = 0; j < NB; j++) begin
            found = 1'b0;
            for (int i = 0; i < NB; i++) begin
                if (!found && sel[4*i +: 4] == 4'(j)) begin
                    found = 1'b1;
                    h[j] = 1'b1;
                    o[DW*j +: DW] = d[DW*i +: DW];
                end
            end
        end
    endfunction

    bit            sv [64];
    bit            sf [64];
    logic [SW-1:0] ss [64];
    logic [BW-1:0] sd [64];
    logic [BW-1:0] e_d [3];
    logic [NB-1:0] e_h [3];
    int            lat [3];
    logic [BW-1:0] hand;

    initial begin
        lat[0] = 1; lat[1] = 2; lat[2] = 3;
        for (int i = 0; i < NB; i++) hand[DW*i +: DW] = 12'(100 + i);

        // Reset state
        #2;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset rdata u%0d", u), rd[u], '0);
            check($sformatf("reset valid u%0d", u), BW'(rv[u]), '0);
            check($sformatf("reset hit u%0d", u), BW'(hit[u]), '0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Identity, RD_LAT 1 then 2
        @(negedge clk);
        sel_a_bus = make_sel(0, 0); dset = hand; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        check("id early valid", BW'(rv[0]), '0);
        @(negedge clk);
        check("id valid", BW'(rv[0]), BW'(1));
        check("id lane0", BW'(rd[0][DW*0 +: DW]), BW'(12'd100));
        check("id lane5", BW'(rd[0][DW*5 +: DW]), BW'(12'd105));
        check("id lane15", BW'(rd[0][DW*15 +: DW]), BW'(12'd115));
        check("id hit", BW'(hit[0]), BW'(16'hFFFF));
        @(negedge clk);
        check("id one-shot", BW'(rv[0]), '0);
        check("id lat2 valid", BW'(rv[1]), BW'(1));
        check("id lat2 lane15", BW'(rd[1][DW*15 +: DW]), BW'(12'd115));

        // Duplicate selects: banks 3 and 9 both pick lane 5, lane 7 unfed
        sel_a_bus = make_sel(4, 0); issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        check("dup valid", BW'(rv[0]), BW'(1));
        check("dup lane5", BW'(rd[0][DW*5 +: DW]), BW'(12'd103));
        check("dup lane3", BW'(rd[0][DW*3 +: DW]), BW'(12'd105));
        check("dup lane9", BW'(rd[0][DW*9 +: DW]), BW'(12'd107));
        check("dup lane7", BW'(rd[0][DW*7 +: DW]), '0);
        check("dup hit", BW'(hit[0]), BW'(16'hFF7F));
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
        check("dup perm_err", BW'(pe[0]), BW'(1));
`endif

        // Reverse with q_i = i
        for (int i = 0; i < NB; i++) dset[DW*i +: DW] = 12'(i);
        sel_a_bus = make_sel(1, 0); issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        check("rev lane2", BW'(rd[0][DW*2 +: DW]), BW'(12'd13));
        check("rev lane15", BW'(rd[0][DW*15 +: DW]), '0);
        check("rev hit", BW'(hit[0]), BW'(16'hFFFF));

        // Reset mid-flight: everything in flight is lost
        dset = hand; sel_a_bus = make_sel(0, 0); issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0; rst_n = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("midrst rdata u%0d", u), rd[u], '0);
            check($sformatf("midrst hit u%0d", u), BW'(hit[u]), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int u = 0; u < 3; u++)
                check($sformatf("midrst no valid u%0d c%0d", u, c), BW'(rv[u]), '0);
        end

        // Cycle schedule: patterns, streaming, flush
        for (int m = 0; m < 64; m++) begin
            sv[m] = 1'b0; sf[m] = 1'b0; ss[m] = make_sel(0, 0); sd[m] = make_data(m);
        end
        sv[0] = 1'b1;
        sv[2] = 1'b1; ss[2] = make_sel(1, 0);
        sv[4] = 1'b1; ss[4] = make_sel(2, 0);
        sv[6] = 1'b1; ss[6] = make_sel(4, 0);
        for (int k = 0; k < 8; k++) begin
            sv[10+k] = 1'b1; ss[10+k] = make_sel(3, k);
        end
        sv[25] = 1'b1; ss[25] = make_sel(3, 3);
        sf[26] = 1'b1;
        sv[27] = 1'b1; ss[27] = make_sel(3, 5);
        sv[35] = 1'b1; sf[35] = 1'b1;

        // Outputs start from reset: zero data, zero hit mask
        for (int u = 0; u < 3; u++) begin
            e_d[u] = '0; e_h[u] = '0;
        end
        for (int n = 0; n < NT; n++) begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                bit ev;
                int s;
                ev = 1'b0;
                s  = n - lat[u] - 1;
                if (s >= 0) begin
                    ev = sv[s];
                    for (int x = s; x < n; x++) if (sf[x]) ev = 1'b0;
                end
                if (ev) route_model(ss[s], sd[s], e_d[u], e_h[u]);
                check($sformatf("valid L%0d n%0d", lat[u], n), BW'(rv[u]), BW'(ev));
                check($sformatf("rdata L%0d n%0d", lat[u], n), rd[u], e_d[u]);
                check($sformatf("hit L%0d n%0d", lat[u], n), BW'(hit[u]), BW'(e_h[u]));
`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
                check($sformatf("perm_err L%0d n%0d", lat[u], n), BW'(pe[u]),
                      BW'(ev && (e_h[u] != 16'hFFFF)));
`endif
            end
            issue_valid = sv[n];
            sel_a_bus   = ss[n];
            dset        = sd[n];
            flush       = sf[n];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
